// File: rtl/snn_lif_core.sv
// Two-neuron leaky-integrate-and-fire core: synchronised input spike edges feed a
// fully connected 2x2 signed weight matrix; leak, threshold and refractory run on a divided tick.
module snn_lif_core #(
    parameter int MEM_W      = 12,
    parameter int W_W        = 8,
    parameter logic signed [W_W-1:0] W00 = 60,
    parameter logic signed [W_W-1:0] W01 = 20,
    parameter logic signed [W_W-1:0] W10 = -30,
    parameter logic signed [W_W-1:0] W11 = 70,
    parameter int THRESH     = 100,
    parameter int LEAK_SHIFT = 3,
    parameter int TICK_DIV   = 16,
    parameter int REFRAC     = 2,
    parameter int PULSE_LEN  = 4
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    en,
    input  logic [1:0]              in_spike,
    output logic [1:0]              out_spike,
    output logic [1:0]              io_oeb,
    output logic signed [MEM_W-1:0] v0_dbg,
    output logic signed [MEM_W-1:0] v1_dbg
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int REF_W = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);
    localparam int PUL_W = $clog2(PULSE_LEN + 1);
    localparam int SUM_W = MEM_W + 2;

    localparam logic signed [SUM_W-1:0] S_MAX = {3'b000, {(MEM_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] S_MIN = {3'b111, {(MEM_W-1){1'b0}}};
    localparam logic signed [MEM_W-1:0] TH    = MEM_W'(THRESH);

    // Input path: two synchroniser stages, then a previous-value stage for edge detection,
    // with the detected edge itself registered so the event is one clean cycle wide.
    logic [1:0] sync1_q, sync1_d;
    logic [1:0] sync2_q, sync2_d;
    logic [1:0] prev_q,  prev_d;
    logic [1:0] ev_q,    ev_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;

    always_comb begin
        sync1_d = in_spike;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        ev_d    = sync2_q & ~prev_q;
    end

    always_comb begin
        tick  = en && (cnt_q == CNT_W'(TICK_DIV - 1));
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            ev_q    <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            ev_q    <= ev_d;
            cnt_q   <= cnt_d;
        end
    end

    logic [1:0][MEM_W-1:0] v_all;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_neuron
            localparam logic signed [W_W-1:0]   WA     = (gi == 0) ? W00 : W10;
            localparam logic signed [W_W-1:0]   WB     = (gi == 0) ? W01 : W11;
            localparam logic signed [SUM_W-1:0] WA_EXT = {{(SUM_W-W_W){WA[W_W-1]}}, WA};
            localparam logic signed [SUM_W-1:0] WB_EXT = {{(SUM_W-W_W){WB[W_W-1]}}, WB};

            logic signed [MEM_W-1:0] v_q, v_d;
            logic [REF_W-1:0]        refrac_q, refrac_d;
            logic [PUL_W-1:0]        pulse_q, pulse_d;
            logic                    out_q, out_d;

            logic [1:0]              ev_use;
            logic signed [SUM_W-1:0] sum;
            logic signed [MEM_W-1:0] s;
            logic signed [MEM_W-1:0] l;
            logic                    fire;

            always_comb begin
                ev_use = (refrac_q == '0) ? ev_q : 2'b00;
                sum    = {{2{v_q[MEM_W-1]}}, v_q};
                if (ev_use[0]) sum = sum + WA_EXT;
                if (ev_use[1]) sum = sum + WB_EXT;

                if (sum > S_MAX)      s = S_MAX[MEM_W-1:0];
                else if (sum < S_MIN) s = S_MIN[MEM_W-1:0];
                else                  s = sum[MEM_W-1:0];

                // Leak is applied to the post-integration value, so tick-cycle events count.
                l    = s - (s >>> LEAK_SHIFT);
                fire = tick && (l >= TH) && (refrac_q == '0);

                v_d      = v_q;
                refrac_d = refrac_q;
                if (en) begin
                    if (!tick) begin
                        v_d = s;
                    end else if (fire) begin
                        v_d      = '0;
                        refrac_d = REF_W'(REFRAC);
                    end else begin
                        v_d = l;
                        if (refrac_q != '0) refrac_d = refrac_q - REF_W'(1);
                    end
                end

                // The pulse stretcher runs regardless of en so an active pulse always completes.
                pulse_d = pulse_q;
                if (fire)                pulse_d = PUL_W'(PULSE_LEN);
                else if (pulse_q != '0)  pulse_d = pulse_q - PUL_W'(1);
                out_d = (pulse_d != '0);
            end

            always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
                if (wb_rst_i) begin
                    v_q      <= '0;
                    refrac_q <= '0;
                    pulse_q  <= '0;
                    out_q    <= 1'b0;
                end else begin
                    v_q      <= v_d;
                    refrac_q <= refrac_d;
                    pulse_q  <= pulse_d;
                    out_q    <= out_d;
                end
            end

            assign v_all[gi]     = v_q;
            assign out_spike[gi] = out_q;
        end
    endgenerate

    assign v0_dbg = v_all[0];
    assign v1_dbg = v_all[1];
    assign io_oeb = 2'b00;

endmodule

// File: tb/tb_snn_lif_core.sv
// Directed bench for snn_lif_core: hand-computed membrane, tick and pulse timing,
// plus a second instance with a long tick window to reach saturation.
module tb_snn_lif_core;

    logic clk;
    logic rst;
    logic en;
    logic [1:0] in_spike;
    logic [1:0] out_spike;
    logic [1:0] io_oeb;
    logic signed [11:0] v0_dbg;
    logic signed [11:0] v1_dbg;

    logic s_en;
    logic [1:0] s_in;
    logic [1:0] s_out;
    logic [1:0] s_oeb;
    logic signed [11:0] s_v0;
    logic signed [11:0] s_v1;

    int total = 0;
    int bad   = 0;
    int cyc;

    snn_lif_core dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .en       (en),
        .in_spike (in_spike),
        .out_spike(out_spike),
        .io_oeb   (io_oeb),
        .v0_dbg   (v0_dbg),
        .v1_dbg   (v1_dbg)
    );

    snn_lif_core #(.TICK_DIV(128)) dut_sat (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .en       (s_en),
        .in_spike (s_in),
        .out_spike(s_out),
        .io_oeb   (s_oeb),
        .v0_dbg   (s_v0),
        .v1_dbg   (s_v1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedge count since reset release; at the negedge after posedge n, cyc == n.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; en = 1'b1; in_spike = 2'b00; s_en = 1'b1; s_in = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic pulse_in(input logic [1:0] m);
        in_spike = m;
        @(negedge clk);
        in_spike = 2'b00;
    endtask

    task automatic pulse_sat(input logic [1:0] m);
        s_in = m;
        @(negedge clk);
        s_in = 2'b00;
    endtask

    task automatic test_reset;
        do_reset();
        wait_cyc(2);
        total++;
        if (v0_dbg !== 12'sd0 || v1_dbg !== 12'sd0) begin
            bad++; $display("FAIL reset_v got v0=%0d v1=%0d want 0 0", v0_dbg, v1_dbg);
        end
        total++;
        if (out_spike !== 2'b00 || io_oeb !== 2'b00) begin
            bad++; $display("FAIL reset_out got out=%b oeb=%b want 00 00", out_spike, io_oeb);
        end
        $display("test_reset done");
    endtask

    task automatic test_single;
        do_reset();
        pulse_in(2'b01);
        wait_cyc(5);
        total++;
        if (v0_dbg !== 12'sd60 || v1_dbg !== -12'sd30) begin
            bad++; $display("FAIL single_int got v0=%0d v1=%0d want 60 -30", v0_dbg, v1_dbg);
        end
        wait_cyc(16);
        total++;
        if (v0_dbg !== 12'sd53 || v1_dbg !== -12'sd26) begin
            bad++; $display("FAIL single_tick1 got v0=%0d v1=%0d want 53 -26", v0_dbg, v1_dbg);
        end
        wait_cyc(32);
        total++;
        if (v0_dbg !== 12'sd47 || v1_dbg !== -12'sd22 || out_spike !== 2'b00) begin
            bad++; $display("FAIL single_tick2 got v0=%0d v1=%0d out=%b want 47 -22 00",
                            v0_dbg, v1_dbg, out_spike);
        end
        $display("test_single done");
    endtask

    task automatic double_fire;
        do_reset();
        pulse_in(2'b01);
        wait_cyc(2);
        pulse_in(2'b01);
    endtask

    task automatic test_fire;
        double_fire();
        wait_cyc(7);
        total++;
        if (v0_dbg !== 12'sd120 || v1_dbg !== -12'sd60) begin
            bad++; $display("FAIL fire_int got v0=%0d v1=%0d want 120 -60", v0_dbg, v1_dbg);
        end
        wait_cyc(15);
        total++;
        if (out_spike !== 2'b00) begin
            bad++; $display("FAIL fire_pre got out=%b want 00", out_spike);
        end
        wait_cyc(16);
        total++;
        if (out_spike !== 2'b01 || v0_dbg !== 12'sd0 || v1_dbg !== -12'sd52) begin
            bad++; $display("FAIL fire_tick got out=%b v0=%0d v1=%0d want 01 0 -52",
                            out_spike, v0_dbg, v1_dbg);
        end
        wait_cyc(19);
        total++;
        if (out_spike !== 2'b01) begin
            bad++; $display("FAIL fire_last got out=%b want 01", out_spike);
        end
        wait_cyc(20);
        total++;
        if (out_spike !== 2'b00) begin
            bad++; $display("FAIL fire_end got out=%b want 00", out_spike);
        end
        $display("test_fire done");
    endtask

    task automatic test_reset_mid_pulse;
        double_fire();
        wait_cyc(17);
        total++;
        if (out_spike !== 2'b01) begin
            bad++; $display("FAIL midrst_pre got out=%b want 01", out_spike);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (out_spike !== 2'b00 || v0_dbg !== 12'sd0 || v1_dbg !== 12'sd0) begin
            bad++; $display("FAIL midrst_async got out=%b v0=%0d v1=%0d want 00 0 0",
                            out_spike, v0_dbg, v1_dbg);
        end
        @(negedge clk);
        rst = 1'b0;
        pulse_in(2'b01);
        wait_cyc(15);
        total++;
        if (v0_dbg !== 12'sd60) begin
            bad++; $display("FAIL midrst_notick got v0=%0d want 60", v0_dbg);
        end
        wait_cyc(16);
        total++;
        if (v0_dbg !== 12'sd53) begin
            bad++; $display("FAIL midrst_tick got v0=%0d want 53", v0_dbg);
        end
        $display("test_reset_mid_pulse done");
    endtask

    task automatic test_simultaneous;
        do_reset();
        pulse_in(2'b11);
        wait_cyc(3);
        total++;
        if (v0_dbg !== 12'sd0 || v1_dbg !== 12'sd0) begin
            bad++; $display("FAIL simul_early got v0=%0d v1=%0d want 0 0", v0_dbg, v1_dbg);
        end
        wait_cyc(4);
        total++;
        if (v0_dbg !== 12'sd80 || v1_dbg !== 12'sd40) begin
            bad++; $display("FAIL simul_int got v0=%0d v1=%0d want 80 40", v0_dbg, v1_dbg);
        end
        $display("test_simultaneous done");
    endtask

    task automatic test_refractory;
        double_fire();
        wait_cyc(20); pulse_in(2'b01);
        wait_cyc(22); pulse_in(2'b01);
        wait_cyc(30);
        total++;
        if (v0_dbg !== 12'sd0 || v1_dbg !== -12'sd112) begin
            bad++; $display("FAIL refrac_w1 got v0=%0d v1=%0d want 0 -112", v0_dbg, v1_dbg);
        end
        wait_cyc(32);
        total++;
        if (v1_dbg !== -12'sd98) begin
            bad++; $display("FAIL refrac_leak got v1=%0d want -98", v1_dbg);
        end
        wait_cyc(36); pulse_in(2'b01);
        wait_cyc(38); pulse_in(2'b01);
        wait_cyc(46);
        total++;
        if (v0_dbg !== 12'sd0 || out_spike !== 2'b00) begin
            bad++; $display("FAIL refrac_w2 got v0=%0d out=%b want 0 00", v0_dbg, out_spike);
        end
        wait_cyc(48);
        total++;
        if (v1_dbg !== -12'sd138) begin
            bad++; $display("FAIL refrac_leak2 got v1=%0d want -138", v1_dbg);
        end
        wait_cyc(52); pulse_in(2'b01);
        wait_cyc(57);
        total++;
        if (v0_dbg !== 12'sd60 || v1_dbg !== -12'sd168) begin
            bad++; $display("FAIL refrac_w3 got v0=%0d v1=%0d want 60 -168", v0_dbg, v1_dbg);
        end
        $display("test_refractory done");
    endtask

    task automatic test_enable;
        do_reset();
        pulse_in(2'b01);
        wait_cyc(5);
        en = 1'b0;
        wait_cyc(8); pulse_in(2'b01);
        wait_cyc(30);
        total++;
        if (v0_dbg !== 12'sd60 || v1_dbg !== -12'sd30) begin
            bad++; $display("FAIL en_hold got v0=%0d v1=%0d want 60 -30", v0_dbg, v1_dbg);
        end
        wait_cyc(40);
        en = 1'b1;
        wait_cyc(50);
        total++;
        if (v0_dbg !== 12'sd60) begin
            bad++; $display("FAIL en_resume got v0=%0d want 60", v0_dbg);
        end
        wait_cyc(51);
        total++;
        if (v0_dbg !== 12'sd53 || v1_dbg !== -12'sd26) begin
            bad++; $display("FAIL en_tick got v0=%0d v1=%0d want 53 -26", v0_dbg, v1_dbg);
        end
        double_fire();
        wait_cyc(16);
        en = 1'b0;
        wait_cyc(19);
        total++;
        if (out_spike !== 2'b01) begin
            bad++; $display("FAIL en_pulse_run got out=%b want 01", out_spike);
        end
        wait_cyc(20);
        total++;
        if (out_spike !== 2'b00) begin
            bad++; $display("FAIL en_pulse_end got out=%b want 00", out_spike);
        end
        en = 1'b1;
        $display("test_enable done");
    endtask

    task automatic test_saturation;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            wait_cyc(2 * i);
            if (i == 29) begin
                total++;
                if (s_v1 !== 12'sd1960) begin
                    bad++; $display("FAIL sat_28 got v1=%0d want 1960", s_v1);
                end
            end
            if (i == 30) begin
                total++;
                if (s_v1 !== 12'sd2030) begin
                    bad++; $display("FAIL sat_29 got v1=%0d want 2030", s_v1);
                end
            end
            if (i == 31) begin
                total++;
                if (s_v1 !== 12'sd2047 || s_v0 !== 12'sd600) begin
                    bad++; $display("FAIL sat_clamp got v1=%0d v0=%0d want 2047 600", s_v1, s_v0);
                end
            end
            pulse_sat(2'b10);
        end
        wait_cyc(84);
        total++;
        if (s_v1 !== 12'sd2047 || s_v0 !== 12'sd800) begin
            bad++; $display("FAIL sat_all got v1=%0d v0=%0d want 2047 800", s_v1, s_v0);
        end
        s_en = 1'b0;
        wait_cyc(104);
        s_en = 1'b1;
        wait_cyc(147);
        total++;
        if (s_v1 !== 12'sd2047 || s_out !== 2'b00) begin
            bad++; $display("FAIL sat_pre got v1=%0d out=%b want 2047 00", s_v1, s_out);
        end
        wait_cyc(148);
        total++;
        if (s_v1 !== 12'sd0 || s_v0 !== 12'sd0 || s_out !== 2'b11) begin
            bad++; $display("FAIL sat_fire got v1=%0d v0=%0d out=%b want 0 0 11", s_v1, s_v0, s_out);
        end
        $display("test_saturation done");
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; in_spike = 2'b00; s_en = 1'b0; s_in = 2'b00;
        test_reset();
        test_single();
        test_fire();
        test_reset_mid_pulse();
        test_simultaneous();
        test_refractory();
        test_enable();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
